// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported unified memory between the fetch
// stage and the MEM stage. Data accesses win contention, except that a
// starvation counter hands the memory to fetch after STARVE_MAX consecutive
// data grants made while fetch was waiting. One access is in flight at a
// time; read data and the one-cycle ack pulse are registered.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,   // 1..7
  parameter int STARVE_MAX = 4    // 1..15
) (
  input  logic                risc_clk,
  input  logic                rst,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  output logic                if_stall,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                d_stall,
  // memory port
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);

  logic [1:0]        state_q,     state_d;
  logic              owner_q,     owner_d;      // 1 = data, 0 = fetch
  logic [2:0]        lat_q,       lat_d;
  logic [3:0]        starve_q,    starve_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q,    mem_be_d;
  logic              if_ack_q,    if_ack_d;
  logic              d_ack_q,     d_ack_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

  // A requester is not eligible during its own ack cycle.
  logic if_elig, d_elig, grant_d, grant_if;
  assign if_elig  = if_req & ~if_ack_q;
  assign d_elig   = d_req  & ~d_ack_q;
  assign grant_d  = d_elig & (~if_elig | (starve_q != STARVE_LIM));
  assign grant_if = if_elig & ~grant_d;

  // Next-state logic: arbitration in IDLE, strobe in ISSUE, latency count in WAIT.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d     = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          state_d     = ISSUE;
          if (if_elig && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (grant_if) begin
          owner_d    = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_be_d   = '1;
          starve_d   = 4'd0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          if (owner_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight access and clears all outputs.
  always_ff @(posedge risc_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lat_q       <= 3'd0;
      starve_q    <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign d_stall   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a transaction-level
// reference model checked every cycle, plus literal spot checks.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int SMAX = 4;

  logic          risc_clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack, if_stall;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_be = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack, d_stall;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .risc_clk (risc_clk), .rst (rst),
    .if_req (if_req), .if_addr (if_addr), .if_rdata (if_rdata),
    .if_ack (if_ack), .if_stall (if_stall),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_be (d_be), .d_rdata (d_rdata), .d_ack (d_ack), .d_stall (d_stall),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .mem_be (mem_be), .mem_rdata (mem_rdata),
    .busy (busy)
  );

  always #5 risc_clk = ~risc_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Memory contents; unlisted addresses return a pattern derived from the address.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory responder with one cycle of latency; junk outside the valid cycle.
  always @(posedge risc_clk or negedge rst) begin
    if (!rst)        mem_rdata <= '0;
    else if (mem_en) mem_rdata <= rd_mem(mem_addr);
    else             mem_rdata <= 32'hBAD0_BAD0;
  end

  // Reference model: one transaction in flight, described by its age in
  // cycles since the grant; expected outputs follow from that age.
  int          m_age;
  bit          m_owner_d;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  logic [3:0]  m_be;
  int          m_starve;
  bit          m_if_ack, m_d_ack;

  always @(negedge risc_clk) begin
    bit nx_if_ack, nx_d_ack, f_wait, d_wait;
    if (!rst) begin
      m_age = 0; m_owner_d = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
      m_starve = 0; m_if_ack = 0; m_d_ack = 0; m_if_rdata = 0; m_d_rdata = 0;
    end
    check("cyc_mem_en",    mem_en,    m_age == 1);
    check("cyc_busy",      busy,      m_age != 0);
    check("cyc_mem_we",    mem_we,    m_we);
    check("cyc_mem_addr",  mem_addr,  m_addr);
    check("cyc_mem_wdata", mem_wdata, m_wdata);
    check("cyc_mem_be",    mem_be,    m_be);
    check("cyc_if_ack",    if_ack,    m_if_ack);
    check("cyc_d_ack",     d_ack,     m_d_ack);
    check("cyc_if_rdata",  if_rdata,  m_if_rdata);
    check("cyc_d_rdata",   d_rdata,   m_d_rdata);
    check("cyc_if_stall",  if_stall,  if_req & ~m_if_ack);
    check("cyc_d_stall",   d_stall,   d_req & ~m_d_ack);
    if (rst) begin
      nx_if_ack = 0;
      nx_d_ack  = 0;
      if (m_age == 1 + LAT) begin
        if (m_owner_d) begin
          nx_d_ack = 1;
          if (!m_we) m_d_rdata = rd_mem(m_addr);
        end else begin
          nx_if_ack  = 1;
          m_if_rdata = rd_mem(m_addr);
        end
        m_age = 0;
      end else if (m_age != 0) begin
        m_age++;
      end else begin
        f_wait = if_req && !m_if_ack;
        d_wait = d_req && !m_d_ack;
        if (d_wait && (!f_wait || m_starve < SMAX)) begin
          m_owner_d = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
          if (f_wait && m_starve < SMAX) m_starve++;
          m_age = 1;
        end else if (f_wait) begin
          m_owner_d = 0; m_we = 0; m_addr = if_addr; m_be = 4'hF;
          m_starve = 0;
          m_age = 1;
        end
      end
      m_if_ack = nx_if_ack;
      m_d_ack  = nx_d_ack;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge risc_clk);
    #1;
  endtask

  // Four data wins against a waiting fetch, then fetch must win.
  task automatic starve_round(input logic [31:0] da, input logic [31:0] fa);
    d_we = 0; d_be = 4'hF; d_addr = da; d_req = 1;
    if_addr = fa; if_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("starve_data_en",   mem_en,   1'b1);
      check("starve_data_addr", mem_addr, da);
      tick(2);
      check("starve_data_ack",  d_ack,    1'b1);
      if_req = 0;
      tick(1);
      if_req = 1;
    end
    tick(1);
    check("starve_fetch_en",   mem_en,   1'b1);
    check("starve_fetch_addr", mem_addr, fa);
    d_req = 0;
    tick(2);
    check("starve_fetch_ack",  if_ack,   1'b1);
    if_req = 0;
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h0000_0000] = 32'h0000_0013;
    mem[32'h0000_0040] = 32'h1234_5678;
    mem[32'h0000_0100] = 32'h00A0_0093;
    mem[32'h0000_0104] = 32'h0010_0073;
    mem[32'h0000_0300] = 32'h1122_3344;
    mem[32'h0000_0500] = 32'hCAFE_F00D;

    rst = 0;
    tick(3);
    check("rst_busy",   busy,   1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    rst = 1;
    tick(1);

    // Reset in the middle of a fetch read.
    if_addr = 32'h40; if_req = 1;
    tick(1);
    check("rst_seq_en", mem_en, 1'b1);
    tick(1);
    #2 rst = 0;
    #1;
    check("async_mem_en",    mem_en,    1'b0);
    check("async_mem_we",    mem_we,    1'b0);
    check("async_mem_addr",  mem_addr,  32'h0);
    check("async_mem_wdata", mem_wdata, 32'h0);
    check("async_mem_be",    mem_be,    4'h0);
    check("async_if_ack",    if_ack,    1'b0);
    check("async_d_ack",     d_ack,     1'b0);
    check("async_if_rdata",  if_rdata,  32'h0);
    check("async_d_rdata",   d_rdata,   32'h0);
    check("async_busy",      busy,      1'b0);
    if_req = 0;
    tick(1);
    rst = 1;
    repeat (4) begin
      check("no_ack_after_rst", if_ack, 1'b0);
      tick(1);
    end
    if_addr = 32'h0; if_req = 1;
    tick(3);
    check("post_rst_ack",   if_ack,   1'b1);
    check("post_rst_rdata", if_rdata, 32'h0000_0013);
    if_req = 0;
    tick(1);

    // Single fetch.
    if_addr = 32'h100; if_req = 1;
    #1 check("fetch_stall_c0", if_stall, 1'b1);
    tick(1);
    check("fetch_en_c1",   mem_en,   1'b1);
    check("fetch_addr_c1", mem_addr, 32'h100);
    check("fetch_we_c1",   mem_we,   1'b0);
    check("fetch_be_c1",   mem_be,   4'hF);
    tick(1);
    check("fetch_stall_c2", if_stall, 1'b1);
    tick(1);
    check("fetch_ack_c3",   if_ack,   1'b1);
    check("fetch_rdata_c3", if_rdata, 32'h00A0_0093);
    check("fetch_stall_c3", if_stall, 1'b0);
    if_req = 0;
    tick(1);
    check("fetch_ack_c4", if_ack, 1'b0);

    // Data write.
    d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3; d_req = 1;
    tick(1);
    check("wr_en_c1",    mem_en,    1'b1);
    check("wr_we_c1",    mem_we,    1'b1);
    check("wr_addr_c1",  mem_addr,  32'h200);
    check("wr_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
    check("wr_be_c1",    mem_be,    4'h3);
    tick(2);
    check("wr_ack_c3",   d_ack,   1'b1);
    check("wr_rdata_c3", d_rdata, 32'h0);
    d_req = 0; d_we = 0;
    tick(1);

    // Simultaneous requests: data first, fetch granted in the data ack cycle.
    if_addr = 32'h104; if_req = 1;
    d_addr = 32'h300; d_be = 4'hF; d_req = 1;
    tick(1);
    check("sim_d_en_c1",   mem_en,   1'b1);
    check("sim_d_addr_c1", mem_addr, 32'h300);
    tick(2);
    check("sim_d_ack_c3",   d_ack,   1'b1);
    check("sim_d_rdata_c3", d_rdata, 32'h1122_3344);
    check("sim_if_ack_c3",  if_ack,  1'b0);
    d_req = 0;
    tick(1);
    check("sim_f_en_c4",   mem_en,   1'b1);
    check("sim_f_addr_c4", mem_addr, 32'h104);
    tick(2);
    check("sim_f_ack_c6",   if_ack,   1'b1);
    check("sim_f_rdata_c6", if_rdata, 32'h0010_0073);
    if_req = 0;
    tick(1);

    // Starvation guard, twice: the second round shows the counter was cleared.
    starve_round(32'h600, 32'h108);
    starve_round(32'h700, 32'h10C);

    // Early drop of a data read.
    d_we = 0; d_addr = 32'h500; d_be = 4'hF; d_req = 1;
    tick(2);
    d_req = 0;
    tick(1);
    check("drop_ack_c3",   d_ack,   1'b1);
    check("drop_rdata_c3", d_rdata, 32'hCAFE_F00D);
    repeat (3) begin
      tick(1);
      check("drop_no_reissue", mem_en, 1'b0);
    end

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-ported unified instruction/data memory between the fetch stage and the MEM stage of the pipelined RISC_V core, so one memory macro serves both. It also produces the stall signals the pipeline uses to freeze on a pending access. The block accepts held request/acknowledge transactions from the two requesters, issues one registered access at a time to the memory, and returns registered read data with a one-cycle acknowledge. Data accesses have priority, and a starvation guard guarantees forward progress for fetch.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 wide)
- MEM_LAT, 1, cycles from the mem_en cycle until mem_rdata is valid; legal range 1..7
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; legal range 1..15

Ports:
- risc_clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_rdata  out  DATA_W  fetch read data; valid when if_ack is high, holds its value otherwise
- if_ack  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_ack (combinational)
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables; for reads, passed through to memory
- d_rdata  out  DATA_W  data read result; valid with d_ack
- d_ack  out  1  one-cycle completion pulse for data
- d_stall  out  1  d_req & ~d_ack (combinational)
- mem_en  out  1  one-cycle access strobe
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered access attributes, valid while mem_en is high
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high when the FSM is not in IDLE

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Eligible requesters are if_req & ~if_ack and d_req & ~d_ack. A requester is masked during its own ack cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, data is granted unless starve_cnt == STARVE_MAX, in which case fetch is granted.
  - On a grant: latch the attributes into the mem_* registers, record the owner, and go to ISSUE.
  - Fetch requests are always treated as reads, with mem_be all ones.
- ISSUE: mem_en = 1 for exactly this cycle. Load lat_cnt = MEM_LAT and go to WAIT.
- WAIT:
  - Decrement lat_cnt each cycle.
  - On the cycle lat_cnt == 1: capture mem_rdata into the owner's rdata register (reads only; writes leave d_rdata unchanged), set the owner's ack for the next cycle, and return to IDLE.
- Starvation counter starve_cnt (4 bits):
  - Increments on a data grant made while if_req & ~if_ack is high. Saturates at STARVE_MAX.
  - Cleared on any fetch grant.
  - Unchanged on a data grant made while fetch is not waiting.
- Dropping req before ack violates the protocol. The access still completes and the ack pulse is still produced.
- Address, data and byte enables pass through unmodified; no alignment checks.
- Reset (rst = 0, at any time, including mid-access):
  - FSM goes to IDLE and the in-flight access is abandoned.
  - All outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, mem_be, if_ack, d_ack, if_rdata, d_rdata, busy.
  - starve_cnt = 0.
  - No ack is generated for an abandoned access.

## Timing

- Request first seen high in IDLE during cycle c:
  - ISSUE (mem_en high) in cycle c+1.
  - mem_rdata sampled at the end of cycle c+1+MEM_LAT.
  - ack high in cycle c+2+MEM_LAT.
  - Latency = MEM_LAT+2 cycles (3 cycles at MEM_LAT = 1).
- The FSM is in IDLE during the ack cycle. The other requester can be granted in that cycle, so its mem_en follows in the next cycle.
- The same requester can re-request at the earliest in the cycle after its ack.
- Steady-state throughput: one access per MEM_LAT+2 cycles.
- mem_* outputs are registered and hold their values between accesses. Only mem_en qualifies them.
- if_rdata and d_rdata hold their values until the next completed read for that requester.

## Test plan

All scenarios use MEM_LAT = 1 and STARVE_MAX = 4.

- Reset: assert rst = 0 mid-WAIT of a read to 0x40 → all outputs 0 immediately (asynchronous), no ack after release; the next if_req at 0x0 completes normally.
- Single fetch: if_req at 0x100 in cycle 0, memory returns 0x00A00093 → mem_en in cycle 1 with mem_addr = 0x100, mem_we = 0, mem_be = 0xF; if_ack and if_rdata = 0x00A00093 in cycle 3; if_stall high in cycles 0–2.
- Data write: d_req, d_we = 1, d_addr = 0x200, d_wdata = 0xDEADBEEF, d_be = 0x3 → mem_en cycle 1 with exactly those attributes; d_ack in cycle 3; d_rdata unchanged.
- Simultaneous requests: if_req and d_req both high in cycle 0 → data granted first (d_ack in cycle 3); fetch granted in cycle 3 with mem_en in cycle 4 and if_ack in cycle 6.
- Starvation: d_req held high continuously (re-asserted after each ack) while if_req waits → exactly 4 data accesses, then the fetch is granted; starve_cnt returns to 0.
- Early drop: d_req dropped in cycle 2 of a read → d_ack still pulses in cycle 3; no second access is issued.
